// File: rtl/shot_queue_if.sv
// Processor-side bundle of the shot queue: break-beam pulses and control in,
// head entry and status out.
interface shot_queue_if #(
    parameter int DEPTH = 4
);
    logic [6:0]              beam_pulse;
    logic                    new_game;
    logic                    pop;
    logic [2:0]              head_col;
    logic                    head_player;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    FABINT;

    modport master (
        output beam_pulse, new_game, pop,
        input  head_col, head_player, count, overflow, FABINT
    );

    modport slave (
        input  beam_pulse, new_game, pop,
        output head_col, head_player, count, overflow, FABINT
    );
endinterface

// File: rtl/shot_queue.sv
// Queues {player, column} for each accepted break-beam shot, with a post-shot
// lockout window, a sticky overflow flag and a one-cycle interrupt per shot.
module shot_queue #(
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int DEPTH          = 4
) (
    input logic         clk,
    input logic         rst_n,
    shot_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

    localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_ONE   = LW'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [LW-1:0] r_lock;
    logic          r_turn;
    logic          r_overflow;
    logic          r_fabint;

    logic [2:0]    w_col;
    logic          w_full;
    logic          w_shot;
    logic          w_pop;
    logic          w_push;

    // NOTE: w_col is assigned before the loop so every path writes it and no latch is inferred.
    always_comb begin
        w_col = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bus.beam_pulse[i]) w_col = 3'(i);
        end
    end

    assign w_full = (r_count == FULL_COUNT);
    assign w_shot = (bus.beam_pulse != 7'd0) && (r_lock == '0) && !bus.new_game;
    assign w_pop  = bus.pop && (r_count != '0) && !bus.new_game;
    // A simultaneous pop frees the slot, so a full queue still takes the push.
    assign w_push = w_shot && (!w_full || w_pop);

    // NOTE: storage has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_turn, w_col};
    end

    // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lock     <= '0;
            r_turn     <= 1'b0;
            r_overflow <= 1'b0;
            r_fabint   <= 1'b0;
        end else if (bus.new_game) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lock     <= '0;
            r_turn     <= 1'b0;
            r_overflow <= 1'b0;
            r_fabint   <= 1'b0;
        end else begin
            r_fabint <= w_shot;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_shot) begin
                r_turn <= ~r_turn;
                r_lock <= LOCK_LOAD;
                if (!w_push) r_overflow <= 1'b1;
            end else if (r_lock != '0) begin
                r_lock <= r_lock - LOCK_ONE;
            end
        end
    end

    assign bus.head_col    = (r_count == '0) ? 3'd0 : r_mem[r_rd_ptr][2:0];
    assign bus.head_player = (r_count == '0) ? 1'b0 : r_mem[r_rd_ptr][3];
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.FABINT      = r_fabint;
endmodule

// File: tb/tb_shot_queue.sv
// Directed and randomised checks of shot_queue against a queue-based model
// (LOCKOUT_CYCLES=10, DEPTH=4).
module tb_shot_queue;
    localparam int LOCK  = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    shot_queue_if #(.DEPTH(DEPTH)) bus ();

    shot_queue #(.LOCKOUT_CYCLES(LOCK), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fab_seen = 0;

    // Reference model: queue of {player, col}, turn bit, first edge on which a shot is allowed.
    logic [3:0] mq[$];
    int m_turn = 0;
    int m_ovf = 0;
    int m_fab = 0;
    int m_unlock = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_turn = 0;
        m_ovf = 0;
        m_fab = 0;
        m_unlock = cyc;
    endtask

    task automatic model_edge(logic [6:0] b, logic ng, logic p);
        bit shot;
        bit pop_ok;
        int col;
        if (ng) begin
            model_clear();
            return;
        end
        shot   = (b != 7'd0) && (cyc >= m_unlock);
        pop_ok = p && (mq.size() > 0);
        if (pop_ok) void'(mq.pop_front());
        if (shot) begin
            col = 0;
            while (!b[col]) col++;
            if (mq.size() < DEPTH) mq.push_back({m_turn[0], col[2:0]});
            else m_ovf = 1;
            m_turn ^= 1;
            m_unlock = cyc + LOCK + 1;
        end
        m_fab = shot ? 1 : 0;
    endtask

    task automatic check_outputs(string tag);
        int exp_col;
        int exp_ply;
        exp_col = (mq.size() > 0) ? int'(mq[0][2:0]) : 0;
        exp_ply = (mq.size() > 0) ? int'(mq[0][3]) : 0;
        chk({tag, "_count"},  32'(bus.count), mq.size());
        chk({tag, "_col"},    32'(bus.head_col), exp_col);
        chk({tag, "_player"}, 32'(bus.head_player), exp_ply);
        chk({tag, "_ovf"},    32'(bus.overflow), m_ovf);
        chk({tag, "_fabint"}, 32'(bus.FABINT), m_fab);
    endtask

    task automatic step(logic [6:0] b, logic ng, logic p, string tag);
        bus.beam_pulse = b;
        bus.new_game   = ng;
        bus.pop        = p;
        @(posedge clk);
        cyc++;
        model_edge(b, ng, p);
        #1;
        check_outputs(tag);
        if (bus.FABINT === 1'b1) fab_seen++;
        bus.beam_pulse = 7'd0;
        bus.new_game   = 1'b0;
        bus.pop        = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step(7'd0, 1'b0, 1'b0, "idle");
    endtask

    task automatic shot(int col, string tag);
        step(7'(1 << col), 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs({tag, "_async"});
        @(posedge clk);
        cyc++;
        #1;
        check_outputs({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cols[5];
        logic [6:0] rb;
        logic rp;
        logic rn;

        bus.beam_pulse = 7'd0;
        bus.new_game   = 1'b0;
        bus.pop        = 1'b0;

        do_reset("reset");
        idle(1);

        // First shot after reset: column 2, player A, one FABINT pulse.
        step(7'b0000100, 1'b0, 1'b0, "r029_shot");
        chk("r029_fab", 32'(bus.FABINT), 1);
        chk("r029_col", 32'(bus.head_col), 2);
        chk("r029_cnt", 32'(bus.count), 1);
        idle(1);
        chk("r029_fab_once", 32'(bus.FABINT), 0);

        // Multi-bit pulse picks lowest column; lockout window boundaries.
        step(7'd0, 1'b1, 1'b0, "r030_ng");
        step(7'b0101000, 1'b0, 1'b0, "r030_shot");
        chk("r030_col", 32'(bus.head_col), 3);
        idle(4);
        step(7'b0000001, 1'b0, 1'b0, "r030_locked");
        chk("r030_locked_cnt", 32'(bus.count), 1);
        idle(5);
        step(7'b1000000, 1'b0, 1'b0, "r030_free");
        chk("r030_free_cnt", 32'(bus.count), 2);
        step(7'd0, 1'b0, 1'b1, "r030_pop");
        chk("r030_col2", 32'(bus.head_col), 6);
        chk("r030_ply2", 32'(bus.head_player), 1);

        // Five shots into a four-deep queue.
        step(7'd0, 1'b1, 1'b0, "r031_ng");
        cols = '{0, 1, 4, 5, 6};
        fab_seen = 0;
        for (int i = 0; i < 5; i++) begin
            shot(cols[i], "r031_shot");
            idle(LOCK);
        end
        chk("r031_cnt", 32'(bus.count), 4);
        chk("r031_ovf", 32'(bus.overflow), 1);
        chk("r031_fabs", fab_seen, 5);
        for (int i = 0; i < 4; i++) begin
            chk("r031_pop_col", 32'(bus.head_col), cols[i]);
            chk("r031_pop_ply", 32'(bus.head_player), i % 2);
            step(7'd0, 1'b0, 1'b1, "r031_pop");
        end
        chk("r031_empty", 32'(bus.count), 0);

        // Full queue, shot and pop together.
        step(7'd0, 1'b1, 1'b0, "r032_ng");
        for (int i = 1; i <= 4; i++) begin
            shot(i, "r032_fill");
            idle(LOCK);
        end
        step(7'b0000001, 1'b0, 1'b1, "r032_both");
        chk("r032_cnt", 32'(bus.count), 4);
        chk("r032_ovf", 32'(bus.overflow), 0);
        idle(LOCK);
        repeat (3) step(7'd0, 1'b0, 1'b1, "r032_drain");
        chk("r032_tail_col", 32'(bus.head_col), 0);
        chk("r032_tail_ply", 32'(bus.head_player), 0);

        // Pop on empty, then new_game clears count and overflow.
        step(7'd0, 1'b1, 1'b0, "r033_ng");
        step(7'd0, 1'b0, 1'b1, "r033_pop_empty");
        chk("r033_empty_cnt", 32'(bus.count), 0);
        for (int i = 0; i < 5; i++) begin
            shot(6 - i, "r033_fill");
            idle(LOCK);
        end
        step(7'd0, 1'b0, 1'b1, "r033_pop");
        chk("r033_cnt3", 32'(bus.count), 3);
        chk("r033_ovf1", 32'(bus.overflow), 1);
        step(7'd0, 1'b1, 1'b1, "r033_clear");
        chk("r033_cnt0", 32'(bus.count), 0);
        chk("r033_ovf0", 32'(bus.overflow), 0);
        step(7'b0100000, 1'b0, 1'b0, "r033_after");
        chk("r033_ply", 32'(bus.head_player), 0);

        // Reset during lockout with entries queued.
        step(7'd0, 1'b1, 1'b0, "r034_ng");
        shot(1, "r034_a");
        idle(LOCK);
        shot(2, "r034_b");
        idle(3);
        chk("r034_cnt2", 32'(bus.count), 2);
        do_reset("r034_rst");
        step(7'b0010000, 1'b0, 1'b0, "r034_post");
        chk("r034_post_cnt", 32'(bus.count), 1);
        chk("r034_post_col", 32'(bus.head_col), 4);
        chk("r034_post_fab", 32'(bus.FABINT), 1);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rb = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
            rp = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 99) == 0);
            step(rb, rn, rp, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
